// File: rtl/imem_loader.sv
// Instruction-memory program loader: streams words into imem from word 0 and
// holds the CPU in reset until the last write has committed.
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              xfer_c;

  assign xfer_c = in_valid && in_ready_q;

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer_c) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[ADDR_W-1:0];
          imem_wdata_d = in_data;
          word_count_d = word_count_q + CNT_W'(1);
          if (in_last) begin
            state_d = S_DRAIN;
          end else if (word_count_q == LAST_IDX) begin
            state_d = S_ERR;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
      end
      S_RUN, S_ERR: begin
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ready/error follow the new state; cpu_rst/done lag one cycle so the CPU
    // is released only after the DRAIN-cycle write has been sampled.
    in_ready_d = (state_d == S_LOAD);
    error_d    = (state_d == S_ERR);
    cpu_rst_d  = (state_q != S_RUN);
    done_d     = (state_q == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a queue of expected writes plus
// transaction-level timing expectations for ready, release and overflow.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 6;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        prog[$];
  bit                 was_run = 1'b0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side view: every sampled write must match the next expected one
  always @(posedge clk) begin : mon
    logic [ADDR_W+31:0] e;
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 64'(imem_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e[ADDR_W+31:32]));
        chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic run_load(input int n, input bit term, input int gap_max,
                          input bit gap_fixed, input bit noise);
    int  cnt;
    int  g;
    bit  ovf;
    bit  first;
    cnt   = 0;
    ovf   = 1'b0;
    first = 1'b1;
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_ready", 64'(in_ready), 64'd1);
    chk("ld_cnt", 64'(word_count), 64'd0);
    chk("ld_err", 64'(error), 64'd0);
    if (was_run) chk("reload_lag", 64'(cpu_rst), 64'd0);
    for (int i = 0; i < n; i++) begin
      g = gap_fixed ? gap_max : (gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
      if (i == 0 && gap_fixed) g = 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        start    = noise ? 1'($urandom) : 1'b0;
        tick();
        chk("gap_ready", 64'(in_ready), 64'd1);
        if (first) begin
          chk("hold_rst", 64'(cpu_rst), 64'd1);
          chk("hold_done", 64'(done), 64'd0);
          first = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_data  = (i < prog.size()) ? prog[i] : $urandom;
      in_last  = term && (i == n - 1);
      start    = noise ? 1'($urandom) : 1'b0;
      exp_q.push_back({ADDR_W'(cnt), in_data});
      cnt++;
      tick();
      if (first) begin
        chk("hold_rst", 64'(cpu_rst), 64'd1);
        chk("hold_done", 64'(done), 64'd0);
        first = 1'b0;
      end
      if (!term && cnt == int'(DEPTH)) begin
        ovf = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    chk("cnt_after", 64'(word_count), 64'(cnt));
    if (ovf) begin
      chk("ovf_err", 64'(error), 64'd1);
      chk("ovf_ready", 64'(in_ready), 64'd0);
      chk("ovf_rst", 64'(cpu_rst), 64'd1);
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        tick();
        chk("err_hold", 64'(error), 64'd1);
        chk("err_ready", 64'(in_ready), 64'd0);
        chk("err_rst", 64'(cpu_rst), 64'd1);
        chk("err_done", 64'(done), 64'd0);
        chk("err_cnt", 64'(word_count), 64'(DEPTH));
      end
      was_run = 1'b0;
    end else begin
      chk("drain_ready", 64'(in_ready), 64'd0);
      chk("drain_rst", 64'(cpu_rst), 64'd1);
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      tick();
      chk("t1_rst", 64'(cpu_rst), 64'd1);
      chk("t1_done", 64'(done), 64'd0);
      chk("t1_ready", 64'(in_ready), 64'd0);
      tick();
      chk("rel_rst", 64'(cpu_rst), 64'd0);
      chk("rel_done", 64'(done), 64'd1);
      chk("rel_cnt", 64'(word_count), 64'(cnt));
      chk("rel_err", 64'(error), 64'd0);
      was_run = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpurst"}, 64'(cpu_rst), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(error), 64'd0);
    chk({tag, "_cnt"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    #2;
    check_reset_vals("por");
    #10;
    rst = 1'b0;
    // IDLE ignores the stream
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (2) begin
      tick();
      chk("idle_ready", 64'(in_ready), 64'd0);
      chk("idle_rst", 64'(cpu_rst), 64'd1);
    end
    in_valid = 1'b0;

    prog = '{32'h20080005, 32'h2009000C, 32'h01095020, 32'h08000C00};
    run_load(4, 1'b1, 0, 1'b0, 1'b0);
    prog = {};
    run_load(2, 1'b1, 0, 1'b0, 1'b0);
    prog = '{32'h20080005, 32'h2009000C, 32'h01095020, 32'h08000C00};
    run_load(4, 1'b1, 2, 1'b1, 1'b0);
    prog = {};
    run_load(int'(DEPTH), 1'b0, 0, 1'b0, 1'b0);
    run_load(3, 1'b1, 1, 1'b0, 1'b0);
    run_load(5, 1'b1, 1, 1'b0, 1'b1);
    run_load(1, 1'b1, 0, 1'b0, 1'b0);
    run_load(int'(DEPTH), 1'b1, 0, 1'b0, 1'b1);

    for (int it = 0; it < 10; it++) begin
      int  n;
      bit  term;
      n    = int'($urandom_range(DEPTH, 1));
      term = (n < int'(DEPTH)) ? 1'b1 : 1'($urandom);
      run_load(n, term, int'($urandom_range(2, 0)), 1'b0, 1'($urandom));
    end

    // Abort mid-load with an asynchronous reset
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = $urandom;
      exp_q.push_back({ADDR_W'(i), in_data});
      tick();
    end
    in_data = $urandom;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    was_run = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_ready", 64'(in_ready), 64'd0);
      chk("post_rst_we", 64'(imem_we), 64'd0);
      chk("post_rst_cpurst", 64'(cpu_rst), 64'd1);
    end
    in_valid = 1'b0;
    run_load(3, 1'b1, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory program loader for the single-cycle MIPS CPU. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory word addresses starting at word 0, which maps to TEXT_BASE 0x0000_3000. It holds the CPU in reset for the whole load and releases it only after the last write has committed. It replaces `$readmemh` preloading for hardware bring-up.

## Interface
- DEPTH, 1024: instruction-memory capacity in words.
- ADDR_W, 10: word-address width; DEPTH ≤ 2^ADDR_W.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, RUN and ERR.
- in_valid  input  1  the source presents a word.
- in_data  input  32  instruction word.
- in_last  input  1  marks the final word of the program; qualified by in_valid.
- in_ready  output  1  the loader accepts a word this cycle.
- imem_we  output  1  instruction-memory write enable; registered.
- imem_addr  output  ADDR_W  word index of the write; registered.
- imem_wdata  output  32  write data; registered.
- cpu_rst  output  1  reset to the CPU core; registered; high in every state except RUN.
- done  output  1  high in RUN.
- error  output  1  high in ERR; indicates overflow.
- word_count  output  ADDR_W+1  number of words written in the current or most recent load.

## Operation
- A transfer occurs on any rising edge where in_valid and in_ready are both high. Nothing else counts as a transfer.
- **States:** IDLE, LOAD, DRAIN, RUN, ERR.
- **IDLE:** in_ready=0, cpu_rst=1.
  - start → LOAD. Clears word_count and error.
- **LOAD:** in_ready=1.
  - On each transfer, register imem_we=1, imem_addr=word_count[ADDR_W-1:0] and imem_wdata=in_data, then increment word_count.
  - A transfer with in_last=1 → DRAIN.
  - A transfer with in_last=0 when word_count==DEPTH-1 writes that word and then → ERR. The memory is full and no terminator was received.
  - start is ignored.
- **DRAIN:** lasts one cycle. in_ready=0. The final registered write commits. Then → RUN.
- **RUN:** cpu_rst=0, done=1, in_ready=0.
  - start → LOAD. This clears word_count, and cpu_rst is high again from the next edge.
- **ERR:** error=1, cpu_rst=1, in_ready=0.
  - Leaves only on start (→ LOAD, clears error) or on rst.
- **Write strobe:** imem_we is high for exactly one cycle per transfer and low otherwise.
  - imem_addr and imem_wdata hold their last values when imem_we is low.
- **in_data / in_last:** ignored unless a transfer occurs.
- **word_count:** saturates naturally at DEPTH because ERR stops further transfers. It holds its value in DRAIN, RUN and ERR.
- **Memory contents:** the loader never clears memory. Words beyond the loaded program keep their prior contents.

## Timing
- **Reset values** (asynchronous, on rst high): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, word_count=0.
- **Start:** start sampled at edge E → state LOAD and in_ready=1 from E.
- **Write latency:** a transfer at edge T puts imem_we/imem_addr/imem_wdata on the memory during T..T+1. The memory samples the write at T+1.
- **Back-to-back:** transfers may occur on consecutive edges, one word per cycle sustained. Gaps in in_valid insert idle cycles with imem_we=0.
- **Release:** last transfer at edge T → DRAIN during T..T+1 → RUN at T+1. cpu_rst and done switch at edge T+2, one full cycle after the final write commits.
- **Reload:** start at edge E while in RUN → cpu_rst=1 and done=0 from E+1. The CPU is held before any memory write.
- **Reset mid-load:** the load aborts immediately. At most the write already registered is lost, and no further writes occur.
- **Single-word program:** in_last on the first word is legal; word_count=1.

## Test plan
- **Basic load:** start, then 4 words 0x20080005, 0x2009000C, 0x01095020, 0x08000C00 on consecutive cycles with in_last on the 4th → writes at addr 0..3 with matching data. word_count=4, cpu_rst falls 2 edges after the last transfer, done=1.
- **Backpressure:** same 4 words with in_valid low for 2 cycles between each → exactly 4 imem_we pulses at addr 0..3. No write occurs during the gaps.
- **Overflow:** with DEPTH=4, 4 words without in_last → 4 writes, then error=1, in_ready=0, cpu_rst stays 1, word_count=4. A following start → LOAD with error=0.
- **Reload from RUN:** after the basic load, start then 2 words with in_last on the 2nd → cpu_rst=1 the edge after start, writes at addr 0..1, word_count=2, RUN again.
- **Reset mid-load:** assert rst after 2 of 4 transfers → all outputs at reset values immediately, no further imem_we, state IDLE.
- **Ignored start:** pulse start mid-LOAD → no effect; addresses continue incrementing from the current word_count.
